// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline stall/flush sequencer for the 5-stage core
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_mdu_op,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mdu_done,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    mdu_start   = 1'b0;
    mdu_abort   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (reset) begin
      // Reset silences every control, including any pending abort.
      state_d     = RUN;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (dmem_wait) begin
      // Whole-pipe freeze; redirect and mdu_done are re-presented later.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      mdu_abort  = (state_q == MDU_WAIT);
      flush_inc  = 1'b1;
      state_d    = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (lu || id_mdu_op) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (!lu) begin
              mdu_start = 1'b1;
              state_d   = MDU_WAIT;
            end
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_d = RUN;
          end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves four conditions: load-use hazards, EX-stage control redirects, multi-cycle MDU operations held in ID, and data-memory wait freezes. It also keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_mdu_op  input  1  ID instruction is a multi-cycle mul/div
ex_mem_read  input  1  EX instruction is a load
ex_rd  input  5  destination register of the EX instruction
ex_redirect  input  1  branch/jump taken, resolved in EX
mdu_done  input  1  MDU result valid (1-cycle pulse)
dmem_wait  input  1  data memory not ready; freeze the pipeline
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID write enable
ifid_flush  output  1  IF/ID flush
idex_write  output  1  ID/EX write enable
idex_flush  output  1  ID/EX flush (bubble insert)
exmem_write  output  1  EX/MEM write enable
mdu_start  output  1  start the MDU on ID operands (1-cycle pulse)
mdu_abort  output  1  cancel the in-flight MDU op (1-cycle pulse)
stall_cnt  output  CNT_W  cycles spent bubbling ID/EX
flush_cnt  output  CNT_W  number of redirect flushes

Behaviour:
- State register: RUN or MDU_WAIT. Control outputs are combinational from state and inputs. State and counters update on posedge clk.
- Default outputs, unless a rule below overrides: all writes = 1, flushes = 0, pulses = 0.
- lu (load-use) = ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- Reset high: state -> RUN, counters -> 0. During reset every write, flush and pulse output = 0.
- Reset takes effect mid-MDU_WAIT with no mdu_abort pulse.

RUN, first match wins:
1. dmem_wait: freeze. pc_write, ifid_write, idex_write and exmem_write all = 0; no flush. ex_redirect is ignored because EX is frozen; it is re-presented after the wait ends.
2. ex_redirect: ifid_flush = 1, idex_flush = 1, pc_write = 1 (PC loads the target). flush_cnt += 1.
3. lu: pc_write = 0, ifid_write = 0, idex_flush = 1. stall_cnt += 1. Exactly one bubble, because the load advances to MEM next cycle.
4. id_mdu_op: mdu_start = 1, pc_write = 0, ifid_write = 0, idex_flush = 1, next state MDU_WAIT. stall_cnt += 1.
5. Otherwise: defaults. mdu_done is ignored in RUN.

MDU_WAIT (MDU op held in ID), first match wins:
1. dmem_wait: freeze as in RUN. State holds. A mdu_done pulse in this cycle is not consumed; the MDU holds its result until the next consumed cycle.
2. ex_redirect (older branch kills the MDU op): ifid_flush = 1, idex_flush = 1, pc_write = 1, mdu_abort = 1, next state RUN. flush_cnt += 1.
3. mdu_done: release with defaults. The MDU op moves to EX, next state RUN. lu is not evaluated because EX holds a bubble.
4. Otherwise: pc_write = 0, ifid_write = 0, idex_flush = 1. stall_cnt += 1.

Counters:
- Both counters saturate at all-ones and never wrap.
- stall_cnt and flush_cnt increment only in cycles where reset is low.

Test Plan:
- Load x5, then add x6,x5,x1 (rd 5, rs1 5): exactly 1 cycle with pc_write = 0, ifid_write = 0, idex_flush = 1; stall_cnt = 1. Repeat with ex_rd = 0: no stall.
- ex_redirect = 1 in RUN with lu also true: ifid_flush = idex_flush = 1, pc_write = 1, no stall; flush_cnt = 1, stall_cnt = 0.
- id_mdu_op = 1, mdu_done 4 cycles later: mdu_start pulses once; pc_write = 0 and idex_flush = 1 for 4 cycles total; release cycle has all writes = 1; stall_cnt = 4; state back to RUN.
- In MDU_WAIT, ex_redirect on cycle 2: mdu_abort = 1, both flushes = 1, state RUN; a later stray mdu_done has no effect.
- dmem_wait = 1 for 3 cycles coincident with ex_redirect and mdu_done: all four writes = 0 and no flushes for 3 cycles; redirect is honoured in the first cycle after dmem_wait drops.
- Preload stall_cnt near saturation (CNT_W = 4, 16 stall cycles): value holds at 4'hF. Reset asserted mid-MDU_WAIT: all outputs = 0 and no mdu_abort; next cycle shows RUN defaults with counters = 0.
